spad_stream_ctrl: RTL and testbench
===================================

Name: spad_stream_ctrl

Overview:
- Sequencer in front of the PE scratchpad (one write/read port, combinational read when wen low, synchronous write).
- FILL phase: accepts a valid/ready stream and writes cfg_len words into the spad at addresses 0..len-1.
- DRAIN phase: replays those words cfg_rounds times, in address order, on a registered valid/ready stream toward the MAC datapath.
- Provides the filter/ifmap reuse pattern the PE needs without upstream re-sending data.

Parameters:
- WIDTH, 8, data word width (matches spad WIDTH).
- ADDR, 6, spad address width.
- SIZE, 64, spad depth in words (<= 2^ADDR).

Ports:
- clk  input  1  clock, all flops rising-edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  pulse; begins a fill/drain job, sampled only in IDLE
- cfg_len  input  ADDR+1  words per job, sampled with start
- cfg_rounds  input  8  replay count, sampled with start
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse in DONE
- in_valid  input  1  upstream data valid
- in_ready  output  1  high in FILL only
- in_data  input  WIDTH  upstream data
- spad_wen  output  1  spad write enable
- spad_addr  output  ADDR  spad address
- spad_wrdata  output  WIDTH  spad write data
- spad_rdata  input  WIDTH  spad combinational read data
- out_valid  output  1  output word valid (registered)
- out_ready  input  1  downstream accept
- out_data  output  WIDTH  output word (registered)
- out_last  output  1  marks final word of final round (registered)

Behaviour:
- Reset (async, rst_n=0): state IDLE; all pointers and counters 0; out_valid, out_last, out_data, done = 0. Reset mid-job aborts immediately with no completion pulse. In-flight out_valid drops.
- States: IDLE, FILL, DRAIN, DONE.
- IDLE:
  - in_ready=0, spad_wen=0, spad_addr=0.
  - start=1 latches len and rounds, then moves to FILL.
  - cfg_len > SIZE clamps to SIZE. cfg_rounds=0 is treated as 1.
  - cfg_len=0 goes straight to DONE; no input accepted, no output produced.
- start in any state other than IDLE: ignored.
- FILL:
  - in_ready=1; spad_wen = in_valid; spad_addr = wr_ptr; spad_wrdata = in_data, combinational pass-through.
  - Each accepted beat increments wr_ptr.
  - The beat at wr_ptr == len-1 moves to DRAIN with rd_ptr=0, round=0. Nothing is accepted past len.
- DRAIN:
  - spad_wen=0 and spad_addr=rd_ptr, so the read is combinational.
  - Load condition: issue_pending && (!out_valid || out_ready).
  - On load: out_data <= spad_rdata; out_valid <= 1; out_last <= (rd_ptr==len-1 && round==rounds-1).
  - At rd_ptr==len-1, rd_ptr wraps to 0 and round increments. After the final word is loaded, issue_pending clears.
  - While out_valid && !out_ready, out_data and out_last hold stable.
  - A handshake with no new load clears out_valid.
  - The handshake with out_last=1 moves to DONE and clears out_valid and out_last.
- DONE: done=1 for exactly one cycle, then IDLE. busy is 0 the following cycle.
- Latency and throughput:
  - First out_valid is asserted 1 cycle after entering DRAIN.
  - With out_ready held high, throughput is 1 word/cycle.
  - A job with no stalls takes len + len*rounds + 2 cycles from start to done.
- Width rules: the pointer compare uses the latched len (ADDR+1 bits), so len=SIZE=64 works. The round counter is 8-bit.

Test Plan:
- Fill and replay: len=4, rounds=2, in_data 0x11,0x22,0x33,0x44, out_ready=1 -> spad writes to addrs 0..3; output 11,22,33,44,11,22,33,44; out_last only on the 8th word; done pulses once; busy low after.
- Output backpressure: same job, out_ready toggling 1,0,0,1,... -> out_data/out_last stable during stalls; same 8-word sequence in order; no word dropped or duplicated.
- Bubbly input: in_valid pattern 1,0,1,1,0,1 with len=4 -> spad_wen high only on accepted beats; addresses 0,1,2,3 in order; in_ready drops on the cycle after the 4th beat.
- Edge configs:
  - cfg_len=0 -> done after 2 cycles, no in_ready and no out_valid.
  - cfg_len=100 with SIZE=64 -> exactly 64 words accepted.
  - cfg_rounds=0 -> one replay.
- Reset mid-DRAIN: assert rst_n=0 asynchronously, between clock edges, during round 1 -> out_valid, busy, done go 0 at once. After release, a new start runs a fresh job correctly.
- start while busy: pulse start during FILL with different cfg values -> ignored; the original len/rounds complete unchanged.

Source files
------------

// File: rtl/spad_stream_ctrl.sv
// Scratchpad stream sequencer: fills cfg_len words from an input stream,
// then replays them cfg_rounds times on a registered output stream.
module spad_stream_ctrl #(
    parameter int WIDTH = 8,
    parameter int ADDR  = 6,
    parameter int SIZE  = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [ADDR:0]    cfg_len,
    input  logic [7:0]       cfg_rounds,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             spad_wen,
    output logic [ADDR-1:0]  spad_addr,
    output logic [WIDTH-1:0] spad_wrdata,
    input  logic [WIDTH-1:0] spad_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN,
        DONE
    } state_t;

    localparam logic [ADDR:0] LEN_MAX = (ADDR+1)'(SIZE);
    localparam logic [ADDR:0] ONE     = (ADDR+1)'(1);

    state_t          state;
    logic [ADDR:0]   len;
    logic [ADDR:0]   wr_ptr;
    logic [ADDR:0]   rd_ptr;
    logic [7:0]      rounds;
    logic [7:0]      round;
    logic            issue_pending;

    logic [ADDR:0]   len_c;
    logic [7:0]      rounds_c;
    logic [ADDR:0]   len_m1;
    logic            rd_end;
    logic            last_word;
    logic            load;
    logic            hs;

    assign len_c     = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
    assign rounds_c  = (cfg_rounds == 8'd0) ? 8'd1 : cfg_rounds;
    assign len_m1    = len - ONE;
    assign rd_end    = (rd_ptr == len_m1);
    assign last_word = rd_end && (round == rounds - 8'd1);
    assign hs        = out_valid && out_ready;
    assign load      = (state == DRAIN) && issue_pending
                     && (!out_valid || out_ready);

    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign in_ready    = (state == FILL);
    assign spad_wen    = (state == FILL) && in_valid;
    assign spad_wrdata = in_data;

    always_comb begin
        spad_addr = '0;
        unique case (state)
            FILL:    spad_addr = wr_ptr[ADDR-1:0];
            DRAIN:   spad_addr = rd_ptr[ADDR-1:0];
            default: spad_addr = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            len           <= '0;
            rounds        <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            round         <= '0;
            issue_pending <= 1'b0;
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            out_data      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        len    <= len_c;
                        rounds <= rounds_c;
                        wr_ptr <= '0;
                        state  <= (len_c == '0) ? DONE : FILL;
                    end
                end
                FILL: begin
                    if (in_valid) begin
                        wr_ptr <= wr_ptr + ONE;
                        if (wr_ptr == len_m1) begin
                            state         <= DRAIN;
                            rd_ptr        <= '0;
                            round         <= '0;
                            issue_pending <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (load) begin
                        out_data  <= spad_rdata;
                        out_valid <= 1'b1;
                        out_last  <= last_word;
                        if (rd_end) begin
                            rd_ptr <= '0;
                            round  <= round + 8'd1;
                            if (last_word) begin
                                issue_pending <= 1'b0;
                            end
                        end else begin
                            rd_ptr <= rd_ptr + ONE;
                        end
                    end else if (hs) begin
                        // final word accepted: nothing left to issue
                        out_valid <= 1'b0;
                        if (out_last) begin
                            out_last <= 1'b0;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spad_stream_ctrl.sv
// Bench for spad_stream_ctrl: queue-based job model, per-cycle compare,
// directed jobs covering replay, backpressure, bubbles, edge configs, reset.
module tb_spad_stream_ctrl;

    localparam int W = 8;
    localparam int A = 6;
    localparam int S = 64;

    typedef struct packed {
        logic [A-1:0] a;
        logic [W-1:0] d;
    } wr_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [A:0]   cfg_len = '0;
    logic [7:0]   cfg_rounds = '0;
    logic         busy;
    logic         done;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         spad_wen;
    logic [A-1:0] spad_addr;
    logic [W-1:0] spad_wrdata;
    logic [W-1:0] spad_rdata;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         out_last;

    spad_stream_ctrl #(.WIDTH(W), .ADDR(A), .SIZE(S)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_len(cfg_len), .cfg_rounds(cfg_rounds),
        .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .spad_wen(spad_wen), .spad_addr(spad_addr),
        .spad_wrdata(spad_wrdata), .spad_rdata(spad_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    // scratchpad: synchronous write, combinational read
    logic [W-1:0] mem [S];
    always @(posedge clk) if (spad_wen) mem[spad_addr] <= spad_wrdata;
    assign spad_rdata = mem[spad_addr];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    wr_t        exp_wr[$];
    logic [W:0] exp_out[$];
    logic [W:0] out_log[$];
    bit         filling = 0;
    int         n_wr = 0, n_out = 0, n_done = 0;
    bit         prev_stall = 0, prev_done = 0;
    logic [W:0] prev_word = '0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] dval(int seed, int i);
        int v;
        v = (seed == 0) ? 17 * (i + 1) : i * 37 + seed;
        return v[W-1:0];
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", in_ready, filling && exp_wr.size() > 0);
            if (spad_wen) begin
                chk("wen_on_beat", in_valid && in_ready, 1);
                if (exp_wr.size() == 0) begin
                    chk("spurious_write", spad_wen, 0);
                end else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    chk("wr_addr", spad_addr, w.a);
                    chk("wr_data", spad_wrdata, w.d);
                    n_wr++;
                end
            end
            if (out_valid && out_ready) begin
                if (exp_out.size() == 0) begin
                    chk("spurious_out", out_valid, 0);
                end else begin
                    chk("out_word", {out_last, out_data}, exp_out.pop_front());
                    out_log.push_back({out_last, out_data});
                    n_out++;
                end
            end
            if (prev_stall)
                chk("stall_hold", {out_valid, out_last, out_data},
                    {1'b1, prev_word});
            if (prev_done) chk("idle_after_done", {busy, done}, 0);
            if (done) begin
                n_done++;
                chk("drained_at_done", exp_wr.size() + exp_out.size(), 0);
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_last, out_data};
            prev_done  = done;
        end else begin
            prev_stall = 0;
            prev_done  = 0;
        end
    end

    task automatic run_job(input int len, input int rounds, input int seed,
                           input logic [5:0] ipat, input bit bp,
                           input bit ghost, input int abort_at,
                           output int lat);
        int le, re, idx, c0, nd0, o0;
        logic [W-1:0] d [100];
        le = (len > S) ? S : len;
        re = (rounds == 0) ? 1 : rounds;
        for (int i = 0; i < 100; i++) d[i] = dval(seed, i);
        for (int i = 0; i < le; i++) exp_wr.push_back({A'(i), d[i]});
        for (int r = 0; r < re; r++)
            for (int i = 0; i < le; i++)
                exp_out.push_back({(r == re - 1) && (i == le - 1), d[i]});
        nd0 = n_done;
        o0  = n_out;
        lat = -1;
        idx = 0;
        @(posedge clk); #1;
        start = 1; cfg_len = (A+1)'(len); cfg_rounds = 8'(rounds);
        c0 = cyc;
        @(posedge clk); #1;
        filling = 1;
        for (int t = 0; t < 3000; t++) begin
            start      = ghost && (t == 2);
            cfg_len    = (ghost && t == 2) ? 7'd2 : '1;
            cfg_rounds = (ghost && t == 2) ? 8'd5 : 8'h55;
            in_valid   = ipat[t % 6] && (idx < len);
            in_data    = (idx < len) ? d[idx] : '0;
            out_ready  = bp ? ((t % 4) == 0 || (t % 4) == 3) : 1'b1;
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            if (done) begin
                lat = cyc - c0;
                break;
            end
            if (abort_at > 0 && n_out - o0 >= abort_at) begin
                @(posedge clk); #3;
                rst_n = 0;
                #1;
                chk("abort_outs", {out_valid, busy, done}, 0);
                exp_wr.delete();
                exp_out.delete();
                filling = 0;
                start = 0; in_valid = 0; out_ready = 0;
                @(posedge clk); #1;
                rst_n = 1;
                return;
            end
            @(posedge clk); #1;
        end
        start = 0; in_valid = 0; out_ready = 0;
        chk("done_seen", lat >= 0, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("one_done", n_done - nd0, 1);
        filling = 0;
    endtask

    logic [8:0] t1_exp [8] = '{9'h011, 9'h022, 9'h033, 9'h044,
                               9'h011, 9'h022, 9'h033, 9'h144};

    initial begin
        int lat, w0, o0;
        for (int i = 0; i < S; i++) mem[i] = '0;
        #12;
        chk("reset_ctl", {busy, done, out_valid, out_last, in_ready,
                          spad_wen}, 0);
        chk("reset_data", out_data, 0);
        chk("reset_addr", spad_addr, 0);
        @(posedge clk); #1;
        rst_n = 1;

        out_log.delete();
        run_job(4, 2, 0, 6'b111111, 0, 0, 0, lat);
        chk("t1_latency", lat, 14);
        chk("t1_count", out_log.size(), 8);
        for (int i = 0; i < 8 && i < out_log.size(); i++)
            chk("t1_word", out_log[i], t1_exp[i]);

        out_log.delete();
        run_job(4, 2, 0, 6'b111111, 1, 0, 0, lat);
        chk("t2_count", out_log.size(), 8);
        for (int i = 0; i < 8 && i < out_log.size(); i++)
            chk("t2_word", out_log[i], t1_exp[i]);

        run_job(4, 1, 5, 6'b101101, 0, 0, 0, lat);
        chk("t3_latency", lat, 12);

        o0 = n_out; w0 = n_wr;
        run_job(0, 3, 7, 6'b111111, 0, 0, 0, lat);
        chk("len0_done_by_2", (lat >= 1) && (lat <= 2), 1);
        chk("len0_no_io", (n_out - o0) + (n_wr - w0), 0);

        w0 = n_wr;
        run_job(100, 1, 3, 6'b111111, 0, 0, 0, lat);
        chk("clamp_writes", n_wr - w0, 64);
        chk("clamp_latency", lat, 130);

        o0 = n_out;
        run_job(3, 0, 9, 6'b111111, 0, 0, 0, lat);
        chk("rounds0_count", n_out - o0, 3);
        chk("rounds0_latency", lat, 8);

        run_job(4, 3, 33, 6'b111111, 0, 0, 5, lat);
        run_job(5, 2, 64, 6'b111111, 0, 0, 0, lat);
        chk("post_reset_latency", lat, 17);

        o0 = n_out;
        run_job(4, 2, 51, 6'b111111, 0, 1, 0, lat);
        chk("ghost_latency", lat, 14);
        chk("ghost_count", n_out - o0, 8);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
